pkt_dmux_n: RTL and testbench

Parametrised N-way packet demultiplexer on the 134-bit FPGA-OS packet bus; successor to the three-way dmux. Classifies each packet by inport, ethertype and IP protocol, then buffers the whole packet in a shared store-and-forward RAM with commit/rollback, so oversized or malformed packets are discarded atomically. It forwards each packet to one of `NUM_OUT` output channels, honouring per-channel backpressure. It sits between the FPGA OS receive path and the PGM/LCM/SSM consumers.

---
 rtl/dmux_pkg.sv | 35 +++
 rtl/pkt_buf_ram.sv | 24 ++
 rtl/pkt_dmux_n.sv | 251 +++++++++++++++++++++++++
 tb/tb_pkt_dmux_n.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared types for the N-way packet demultiplexer:
// bus tags, ethertype, descriptor layout and FSM states.
package dmux_pkg;

  localparam int PKT_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PKT,
    W_DISCARD
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_SEND
  } rstate_t;

  typedef struct packed {
    logic [7:0]  ch;
    logic        lcm;
    logic        rd;
    logic [15:0] base;
    logic [15:0] len;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet store, one write port and
// one read port with a registered read.
module pkt_buf_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 134,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_dmux_n.sv
// N-way packet demux: classify, store-and-forward with
// commit/rollback, then forward in order per descriptor.
module pkt_dmux_n
  import dmux_pkg::*;
#(
  parameter int NUM_OUT = 3,
  parameter int BUF_DEPTH = 256,
  parameter int MAX_PKT_WORDS = 128,
  parameter int DESC_DEPTH = 16,
  parameter int CUT_CH = 2,
  parameter int LCM_CH = 1,
  parameter int DEF_CH = 0,
  parameter logic [7:0] PROTO_WR = 8'hC8,
  parameter logic [7:0] PROTO_RD = 8'hC9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [133:0]             pktin_data,
  input  logic                     pktin_data_wr,
  input  logic                     pktin_data_valid,
  input  logic                     pktin_data_valid_wr,
  output logic                     pktin_data_ready,
  output logic [NUM_OUT*134-1:0]   out_data,
  output logic [NUM_OUT-1:0]       out_data_wr,
  output logic [NUM_OUT-1:0]       out_data_valid,
  output logic [NUM_OUT-1:0]       out_data_valid_wr,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [31:0]              drop_cnt
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int PW  = AW + 1;
  localparam int DW  = $clog2(DESC_DEPTH);
  localparam int DPW = DW + 1;

  wstate_t ws;
  rstate_t rs;

  logic [PW-1:0]  wr_ptr, pkt_base, rd_ptr, used;
  logic [15:0]    wcnt;
  logic           cut, ipf, lcm_q, rd_q;
  logic [1:0]     tag;
  logic           is_head, is_tail, is_bt;
  logic           start, cont, over, stray;
  logic           commit, body_c, disc_end, drop_evt;
  logic           proto_hit, lcm_now, rd_now, ready_nx;
  logic [7:0]     proto;
  logic [7:0]     ch_now;
  desc_t          din, head_d, cur;

  logic [DPW-1:0]    dwp, drp, dcnt;
  logic              dempty;
  logic [DESC_W-1:0] dmem [DESC_DEPTH];

  logic          ram_we, ram_re;
  logic [AW-1:0] waddr, raddr, off;
  logic [133:0]  rdata, word;
  logic [15:0]   idx;
  logic          last, rdy;

  assign tag   = pktin_data[133:132];
  assign proto = pktin_data[71:64];

  always_comb begin
    is_head  = tag == TAG_HEAD;
    is_tail  = tag == TAG_TAIL;
    is_bt    = is_tail || tag == TAG_BODY;
    start    = pktin_data_wr && is_head;
    cont     = pktin_data_wr && is_bt && ws == W_PKT &&
               wcnt != 16'(MAX_PKT_WORDS);
    over     = pktin_data_wr && is_bt && ws == W_PKT &&
               wcnt == 16'(MAX_PKT_WORDS);
    stray    = pktin_data_wr && is_bt && ws == W_IDLE;
    commit   = cont && is_tail;
    body_c   = cont && !is_tail;
    disc_end = pktin_data_wr && is_tail && ws == W_DISCARD;
    drop_evt = over || stray || (start && ws == W_PKT);
  end

  // Word 2 may itself be the tail, so classify combinationally
  always_comb begin
    proto_hit = ipf && wcnt == 16'd2 &&
                (proto == PROTO_WR || proto == PROTO_RD);
    lcm_now   = lcm_q || proto_hit;
    rd_now    = proto_hit ? (proto == PROTO_RD) : rd_q;
    if (cut) ch_now = 8'(CUT_CH);
    else if (lcm_now) ch_now = 8'(LCM_CH);
    else ch_now = 8'(DEF_CH);
    din      = '0;
    din.ch   = ch_now;
    din.lcm  = !cut && lcm_now;
    din.rd   = rd_now;
    din.base = 16'(pkt_base[AW-1:0]);
    din.len  = wcnt + 16'd1;
  end

  // Idle/discard states always have wr_ptr == pkt_base
  assign ram_we = start || cont;
  assign waddr  = start ? pkt_base[AW-1:0] : wr_ptr[AW-1:0];

  assign used   = wr_ptr - rd_ptr;
  assign dcnt   = dwp - drp;
  assign dempty = dwp == drp;

  // Ready is judged on the state after this edge
  assign ready_nx =
    (32'(used) + 32'(ram_we) + 32'(MAX_PKT_WORDS)
      <= 32'(BUF_DEPTH)) &&
    (32'(dcnt) + 32'(commit) < 32'(DESC_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      ws               <= W_IDLE;
      wr_ptr           <= '0;
      pkt_base         <= '0;
      wcnt             <= '0;
      cut              <= 1'b0;
      ipf              <= 1'b0;
      lcm_q            <= 1'b0;
      rd_q             <= 1'b0;
      dwp              <= '0;
      drop_cnt         <= '0;
      pktin_data_ready <= 1'b0;
    end else begin
      pktin_data_ready <= ready_nx;
      if (drop_evt && drop_cnt != '1)
        drop_cnt <= drop_cnt + 32'd1;
      if (commit)
        dwp <= dwp + DPW'(1);
      unique case (1'b1)
        start: begin
          ws     <= W_PKT;
          wr_ptr <= pkt_base + PW'(1);
          wcnt   <= 16'd1;
          cut    <= |pktin_data[125:120];
          ipf    <= 1'b0;
          lcm_q  <= 1'b0;
          rd_q   <= 1'b0;
        end
        over: begin
          wr_ptr <= pkt_base;
          ws     <= is_tail ? W_IDLE : W_DISCARD;
        end
        commit: begin
          wr_ptr   <= wr_ptr + PW'(1);
          pkt_base <= wr_ptr + PW'(1);
          ws       <= W_IDLE;
        end
        body_c: begin
          wr_ptr <= wr_ptr + PW'(1);
          wcnt   <= wcnt + 16'd1;
          if (wcnt == 16'd1)
            ipf <= pktin_data[31:16] == ETH_IPV4;
          lcm_q  <= lcm_now;
          rd_q   <= rd_now;
        end
        disc_end: ws <= W_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) dmem[dwp[DW-1:0]] <= din;
  end

  assign head_d = desc_t'(dmem[drp[DW-1:0]]);

  always_comb begin
    rdy = 1'b0;
    for (int c = 0; c < NUM_OUT; c++)
      if (c == int'(cur.ch)) rdy = out_ready[c];
  end

  // Prefetch the next word whenever the current one leaves
  always_comb begin
    off    = (rs == R_SEND) ? idx[AW-1:0] + AW'(1) : '0;
    raddr  = cur.base[AW-1:0] + off;
    ram_re = rs == R_WAIT || (rs == R_SEND && rdy);
    last   = idx == cur.len - 16'd1;
    word   = rdata;
    if (cur.lcm && idx == 16'd0) word[48] = cur.rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs                <= R_IDLE;
      cur               <= '0;
      idx               <= '0;
      drp               <= '0;
      rd_ptr            <= '0;
      out_data          <= '0;
      out_data_wr       <= '0;
      out_data_valid    <= '0;
      out_data_valid_wr <= '0;
    end else begin
      out_data_wr       <= '0;
      out_data_valid    <= '0;
      out_data_valid_wr <= '0;
      unique case (rs)
        R_IDLE: begin
          if (!dempty) begin
            cur <= head_d;
            drp <= drp + DPW'(1);
            idx <= '0;
            rs  <= R_WAIT;
          end
        end
        R_WAIT: rs <= R_SEND;
        R_SEND: begin
          if (rdy) begin
            for (int c = 0; c < NUM_OUT; c++) begin
              out_data[c*134 +: 134] <=
                (c == int'(cur.ch)) ? word : '0;
              out_data_wr[c] <= c == int'(cur.ch);
              out_data_valid[c] <=
                c == int'(cur.ch) && last;
              out_data_valid_wr[c] <=
                c == int'(cur.ch) && last;
            end
            idx <= idx + 16'd1;
            if (last) begin
              rd_ptr <= rd_ptr + PW'(cur.len);
              rs     <= R_IDLE;
            end
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  pkt_buf_ram #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(PKT_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (pktin_data),
    .re    (ram_re),
    .raddr (raddr),
    .rdata (rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{pktin_data_valid,
                         pktin_data_valid_wr,
                         pktin_data, cur};

endmodule

// File: tb/tb_pkt_dmux_n.sv
// Scoreboard bench for pkt_dmux_n: packet-level reference
// model feeds an expected queue, a monitor pops and compares.
module tb_pkt_dmux_n;

  localparam int N    = 3;
  localparam int MAXW = 128;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [133:0]     pktin_data = '0;
  logic             pktin_data_wr = 1'b0;
  logic             pktin_data_valid = 1'b0;
  logic             pktin_data_valid_wr = 1'b0;
  logic             pktin_data_ready;
  logic [N*134-1:0] out_data;
  logic [N-1:0]     out_data_wr;
  logic [N-1:0]     out_data_valid;
  logic [N-1:0]     out_data_valid_wr;
  logic [N-1:0]     out_ready = '1;
  logic [31:0]      drop_cnt;

  pkt_dmux_n #(
    .NUM_OUT(N), .BUF_DEPTH(256), .MAX_PKT_WORDS(MAXW),
    .DESC_DEPTH(16), .CUT_CH(2), .LCM_CH(1), .DEF_CH(0),
    .PROTO_WR(8'hC8), .PROTO_RD(8'hC9)
  ) dut (
    .clk(clk), .rst(rst),
    .pktin_data(pktin_data),
    .pktin_data_wr(pktin_data_wr),
    .pktin_data_valid(pktin_data_valid),
    .pktin_data_valid_wr(pktin_data_valid_wr),
    .pktin_data_ready(pktin_data_ready),
    .out_data(out_data),
    .out_data_wr(out_data_wr),
    .out_data_valid(out_data_valid),
    .out_data_valid_wr(out_data_valid_wr),
    .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           ch;
    logic [133:0] w;
    bit           first;
    bit           last;
  } exp_t;

  exp_t         expq[$];
  logic [133:0] pkt[$];
  int total = 0;
  int bad = 0;
  int model_drops = 0;
  int ready_mode = 0;
  bit lat_armed = 0;
  int tail_t = 0;

  task automatic chk(string name, logic [133:0] act,
                     logic [133:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0: out_ready = '1;
      1: out_ready = {2'b11, ~out_ready[0]};
      2: out_ready = '0;
      default: out_ready = 3'($urandom);
    endcase
  end

  task automatic mon_word();
    int c;
    exp_t e;
    c = 0;
    for (int i = N - 1; i >= 0; i--)
      if (out_data_wr[i]) c = i;
    chk("onehot_wr", 134'($countones(out_data_wr)), 134'd1);
    for (int i = 0; i < N; i++)
      if (i != c)
        chk("idle_ch_data", out_data[i*134 +: 134], '0);
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word ch=%0d got=%h want=none",
               c, out_data[c*134 +: 134]);
    end else begin
      e = expq.pop_front();
      chk("channel", 134'(c), 134'(e.ch));
      chk("data", out_data[c*134 +: 134], e.w);
      chk("valid", 134'(out_data_valid[c]), 134'(e.last));
      chk("valid_wr", 134'(out_data_valid_wr[c]),
          134'(e.last));
      if (e.first && lat_armed) begin
        lat_armed = 0;
        chk("head_latency", 134'(cyc - tail_t), 134'd3);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (((out_data_valid | out_data_valid_wr) &
           ~out_data_wr) != '0) begin
        bad++;
        $display("FAIL strobe_mask got=%b want=subset of %b",
                 out_data_valid | out_data_valid_wr,
                 out_data_wr);
      end
      if (out_data_wr != '0) mon_word();
    end
  end

  // Routing rules from the packet's point of view
  function automatic int classify(output bit rd);
    rd = 0;
    if (pkt[0][125:120] != 6'd0) return 2;
    if (pkt.size() >= 3 && pkt[1][31:16] == 16'h0800 &&
        (pkt[2][71:64] == 8'hC8 || pkt[2][71:64] == 8'hC9)) begin
      rd = pkt[2][71:64] == 8'hC9;
      return 1;
    end
    return 0;
  endfunction

  task automatic expect_pkt();
    exp_t e;
    bit   rd;
    int   ch;
    if (pkt.size() > MAXW) begin
      model_drops++;
      return;
    end
    ch = classify(rd);
    foreach (pkt[i]) begin
      e.ch    = ch;
      e.w     = pkt[i];
      if (ch == 1 && i == 0) e.w[48] = rd;
      e.first = i == 0;
      e.last  = i == pkt.size() - 1;
      expq.push_back(e);
    end
  endtask

  // kind: 0 non-IP, 1 LCM wr, 2 LCM rd, 3 inport, 4 IP other
  task automatic build(int len, int kind);
    logic [159:0] r;
    logic [133:0] w;
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      w = r[133:0];
      w[133:132] = (i == 0) ? 2'b01 :
                   (i == len - 1) ? 2'b10 : 2'b11;
      if (i == 0)
        w[125:120] = (kind == 3) ?
                     6'($urandom_range(1, 63)) : 6'd0;
      if (i == 1)
        w[31:16] = (kind == 0) ? 16'h86DD : 16'h0800;
      if (i == 2)
        w[71:64] = (kind == 1 || kind == 3) ? 8'hC8 :
                   (kind == 2) ? 8'hC9 :
                   (kind == 4) ? 8'h11 : w[71:64];
      pkt.push_back(w);
    end
  endtask

  task automatic drive_raw(input bit arm);
    foreach (pkt[i]) begin
      pktin_data    = pkt[i];
      pktin_data_wr = 1'b1;
      if (arm && i == pkt.size() - 1) begin
        tail_t    = cyc + 1;
        lat_armed = 1;
      end
      @(negedge clk);
    end
    pktin_data_wr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (pktin_data_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=0 want=1");
    end
  endtask

  task automatic send(input bit arm);
    wait_ready();
    expect_pkt();
    drive_raw(arm);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0 pending",
               expq.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic truncated();
    build(3, 1);
    void'(pkt.pop_back());
    wait_ready();
    model_drops++;
    drive_raw(0);
    build($urandom_range(2, 12), $urandom_range(0, 4));
    send(0);
  endtask

  task automatic stray();
    logic [159:0] r;
    logic [133:0] w;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w = r[133:0];
    w[133:132] = 2'b11;
    pkt.delete();
    pkt.push_back(w);
    model_drops++;
    drive_raw(0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit saw_low;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 134'(pktin_data_ready), 134'd0);
    chk("rst_out_wr", 134'(out_data_wr), 134'd0);
    chk("rst_out_data", 134'(|out_data), 134'd0);
    chk("rst_drop", 134'(drop_cnt), 134'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 134'(pktin_data_ready), 134'd1);

    build(4, 2);
    send(1);
    wait_drain();
    build(5, 3);
    send(0);
    build(6, 0);
    send(0);
    wait_drain();

    build(130, 0);
    send(0);
    build(5, 4);
    send(0);
    wait_drain();
    chk("drop_oversize", 134'(drop_cnt), 134'd1);

    truncated();
    wait_drain();
    chk("drop_truncated", 134'(drop_cnt), 134'd2);
    stray();
    repeat (2) @(negedge clk);
    chk("drop_stray", 134'(drop_cnt), 134'd3);

    ready_mode = 1;
    build(10, 0);
    send(0);
    wait_drain();
    ready_mode = 0;

    ready_mode = 2;
    saw_low = 0;
    for (int k = 0; k < 40; k++) begin
      if (!pktin_data_ready) begin
        saw_low = 1;
        break;
      end
      build(8, k % 5);
      expect_pkt();
      drive_raw(0);
    end
    chk("ready_low_full", 134'(saw_low), 134'd1);
    ready_mode = 0;
    wait_ready();
    chk("ready_recover", 134'(pktin_data_ready), 134'd1);
    wait_drain();

    ready_mode = 3;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 19))
        0: stray();
        1: truncated();
        default: begin
          build($urandom_range(2, 14), $urandom_range(0, 4));
          send(0);
        end
      endcase
    end
    ready_mode = 0;
    wait_drain();
    chk("drop_final", 134'(drop_cnt), 134'(model_drops));
    chk("queue_empty", 134'(expq.size()), 134'd0);

    build(6, 0);
    repeat (3) void'(pkt.pop_back());
    wait_ready();
    drive_raw(0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_ready", 134'(pktin_data_ready), 134'd0);
    rst = 1'b0;
    model_drops = 0;
    @(negedge clk);
    chk("rst_mid_drop", 134'(drop_cnt), 134'd0);
    build(4, 1);
    send(0);
    wait_drain();
    chk("post_rst_drop", 134'(drop_cnt), 134'(model_drops));
    chk("post_rst_empty", 134'(expq.size()), 134'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
